// File: rtl/gen_rr_lane_arbiter.sv
// Round-robin arbiter: P requester lanes share one registered valid/ready output stage.
// Optional packet locking (req_last port, LOCKED state) is enabled by defining ARB_LOCK_EN.
module gen_rr_lane_arbiter #(
  parameter int P  = 4,
  parameter int W  = 8,
  parameter int IW = (P > 1) ? $clog2(P) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [P-1:0]   req_valid,
  input  logic [P*W-1:0] req_data,
`ifdef ARB_LOCK_EN
  input  logic [P-1:0]   req_last,
`endif
  output logic [P-1:0]   req_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  input  logic           out_ready,
  output logic [IW-1:0]  grant_idx,
  output logic           busy
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t        state_reg;
  logic [IW-1:0] last_ptr_reg;
  logic [IW-1:0] winner;
  logic [IW-1:0] cand;
  logic [P-1:0]  valid_eff;
  logic [P-1:0]  grant_oh;
  logic          any_req;
  logic          can_load;
  logic          xfer;
  logic [W-1:0]  lane_data [P];

`ifdef ARB_LOCK_EN
  logic          lock_reg;
  logic [IW-1:0] lock_idx_reg;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < P; gi++) begin : g_lane
      assign lane_data[gi] = req_data[gi*W +: W];
`ifdef ARB_LOCK_EN
      // While a packet is in flight only the locked lane may compete.
      assign valid_eff[gi] = req_valid[gi] && (!lock_reg || (lock_idx_reg == IW'(gi)));
`else
      assign valid_eff[gi] = req_valid[gi];
`endif
      assign grant_oh[gi]  = any_req && (winner == IW'(gi));
      assign req_ready[gi] = grant_oh[gi] && can_load;
    end
  endgenerate

  // Search starts one past the last winner and wraps modulo P.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    cand    = '0;
    for (int k = 1; k <= P; k++) begin
      cand = IW'((int'(last_ptr_reg) + k) % P);
      if (!any_req && valid_eff[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  assign out_valid = (state_reg == FULL);
  assign can_load  = !out_valid || out_ready;
  assign xfer      = any_req && can_load;
  assign busy      = out_valid || (|req_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      out_data     <= '0;
      grant_idx    <= '0;
      last_ptr_reg <= IW'(P - 1);
`ifdef ARB_LOCK_EN
      lock_reg     <= 1'b0;
      lock_idx_reg <= '0;
`endif
    end else begin
      if (xfer) begin
        state_reg    <= FULL;
        out_data     <= lane_data[winner];
        grant_idx    <= winner;
        last_ptr_reg <= winner;
`ifdef ARB_LOCK_EN
        if (!lock_reg) begin
          if (!req_last[winner]) begin
            lock_reg     <= 1'b1;
            lock_idx_reg <= winner;
          end
        end else if (req_last[winner]) begin
          lock_reg <= 1'b0;
        end
`endif
      end else if (out_ready) begin
        // Drain without a replacement word; data and index keep their last values.
        state_reg <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_gen_rr_lane_arbiter.sv
// Directed bench for gen_rr_lane_arbiter (P=4, W=8) with hand-computed expectations.
// Exercises the lock sequence when ARB_LOCK_EN is defined, rotation order otherwise.
module tb_gen_rr_lane_arbiter;

  localparam int P  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [P-1:0]   req_valid;
  logic [P*W-1:0] req_data;
  logic [P-1:0]   req_last;
  logic [P-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [IW-1:0]  grant_idx;
  logic           busy;

  int checks = 0;
  int errors = 0;

  gen_rr_lane_arbiter #(.P(P), .W(W), .IW(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
`ifdef ARB_LOCK_EN
    .req_last  (req_last),
`endif
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]   exp_data [5];
  logic [1:0]   exp_idx  [5];
  logic [P-1:0] exp_rdy  [5];

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '1;
    out_ready = 1'b1;
    for (int i = 0; i < P; i++) req_data[i*W +: W] = 8'h10 + 8'(i);
    #1;
    check("reset_out_valid", 32'(out_valid), 0);
    step();
    rst_n = 1'b1;

    // Idle after reset
    for (int c = 0; c < 3; c++) begin
      step();
      check("idle_out_valid", 32'(out_valid), 0);
      check("idle_req_ready", 32'(req_ready), 0);
      check("idle_busy", 32'(busy), 0);
      check("idle_grant_idx", 32'(grant_idx), 0);
    end

    // All lanes requesting: strict rotation starting at lane 0
    exp_data = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    exp_idx  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_rdy  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req_valid = 4'b1111;
    #1;
    check("rr_busy", 32'(busy), 1);
    for (int c = 0; c < 5; c++) begin
      check("rr_req_ready", 32'(req_ready), 32'(exp_rdy[c]));
      step();
      $display("rr beat %0d: out_data=0x%0h grant_idx=%0d", c, out_data, grant_idx);
      check("rr_out_valid", 32'(out_valid), 1);
      check("rr_out_data", 32'(out_data), 32'(exp_data[c]));
      check("rr_grant_idx", 32'(grant_idx), 32'(exp_idx[c]));
    end

    // Lane 1 grant, then sparse requests 1010 -> lane 3, lane 1
    req_valid = 4'b0010;
    #1;
    check("sp_ready_l1", 32'(req_ready), 32'h2);
    step();
    check("sp_idx_l1", 32'(grant_idx), 1);
    req_valid = 4'b1010;
    #1;
    check("sp_ready_l3", 32'(req_ready), 32'h8);
    step();
    check("sp_data_l3", 32'(out_data), 32'h13);
    check("sp_idx_l3", 32'(grant_idx), 3);
    check("sp_ready_l1b", 32'(req_ready), 32'h2);
    step();
    check("sp_data_l1", 32'(out_data), 32'h11);
    check("sp_idx_l1b", 32'(grant_idx), 1);

    // Backpressure: FULL, out_ready=0 for 5 cycles with lane 2 pending
    out_ready = 1'b0;
    req_valid = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_req_ready", 32'(req_ready), 0);
      check("bp_out_data", 32'(out_data), 32'h11);
      check("bp_out_valid", 32'(out_valid), 1);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'h4);
    step();
    check("bp_load_valid", 32'(out_valid), 1);
    check("bp_load_data", 32'(out_data), 32'h12);
    check("bp_load_idx", 32'(grant_idx), 2);

    // Drain without load
    req_valid = '0;
    step();
    check("drain_out_valid", 32'(out_valid), 0);
    check("drain_hold_data", 32'(out_data), 32'h12);
    check("drain_hold_idx", 32'(grant_idx), 2);
    check("drain_busy", 32'(busy), 0);

    // Asynchronous reset while holding a word
    req_valid = 4'b1000;
    out_ready = 1'b0;
    step();
    check("pre_rst_valid", 32'(out_valid), 1);
    check("pre_rst_data", 32'(out_data), 32'h13);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_data", 32'(out_data), 0);
    check("async_rst_idx", 32'(grant_idx), 0);
    step();
    rst_n     = 1'b1;
    req_valid = 4'b1001;
    out_ready = 1'b1;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'h1);
    step();
    check("post_rst_data0", 32'(out_data), 32'h10);
    check("post_rst_idx0", 32'(grant_idx), 0);
    check("post_rst_ready3", 32'(req_ready), 32'h8);
    step();
    check("post_rst_idx3", 32'(grant_idx), 3);

    // Set last_ptr=1, then lanes 0,1,2 request with lane 2 sending a 3-beat packet
    req_valid = 4'b0010;
    req_last  = 4'b1111;
    step();
    check("pkt_setup_idx", 32'(grant_idx), 1);
    req_valid = 4'b0111;
`ifdef ARB_LOCK_EN
    req_last = 4'b0000;
    step();
    check("lock_beat1", 32'(grant_idx), 2);
    step();
    check("lock_beat2", 32'(grant_idx), 2);
    req_last = 4'b0100;
    step();
    check("lock_beat3", 32'(grant_idx), 2);
    req_last = 4'b1111;
    step();
    check("lock_after", 32'(grant_idx), 0);
`else
    step();
    check("rot_g0", 32'(grant_idx), 2);
    step();
    check("rot_g1", 32'(grant_idx), 0);
    step();
    check("rot_g2", 32'(grant_idx), 1);
    step();
    check("rot_g3", 32'(grant_idx), 2);
`endif
    req_valid = '0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gen_rr_lane_arbiter.md
Name: gen_rr_lane_arbiter

Overview:
Round-robin arbiter that shares one registered output stage between P parallel requester lanes. Each lane is built with a generate-for loop. Each lane offers a valid/data word; the block grants one lane per transfer and registers the winner's data into a single output register with a valid/ready handshake. It sits between the per-lane generate blocks and a single downstream consumer.

Parameters:
P, 4, number of requester lanes (1..16)
W, 8, data width per lane
IW, $clog2(P) (1 when P=1), width of grant index

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  P  per-lane request valid
req_data  input  P*W  lane i data at bits [i*W +: W]
req_ready  output  P  per-lane accept, combinational
out_valid  output  1  output register holds a valid word
out_data  output  W  registered winning data
out_ready  input  1  downstream accept
grant_idx  output  IW  lane index of word in out_data
busy  output  1  out_valid OR any req_valid

Behaviour:
- One clock domain: clk. rst_n is asynchronous assert, active-low.
- Reset values: out_valid=0, out_data=0, grant_idx=0, last_ptr=P-1, so lane 0 has first priority. State is EMPTY.
- Output stage states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- can_load = !out_valid || out_ready.
- Arbitration is combinational.
  - Search lanes last_ptr+1, last_ptr+2, ... modulo P (wrap P-1 -> 0).
  - The first lane with req_valid=1 is the winner.
  - At most one grant bit is set.
- req_ready[i] = (i == winner) && can_load. It is 0 for all lanes when there is no request.
- Transfer when req_valid[winner] && req_ready[winner]. On the next edge:
  - out_data <= req_data[winner]
  - grant_idx <= winner
  - last_ptr <= winner
  - out_valid <= 1
- Latency: request to out_valid is 1 cycle.
- Throughput: 1 word/cycle while out_ready=1.
- Simultaneous drain and load (FULL, out_ready=1, a request present): the new word replaces the old in the same edge, no bubble. State stays FULL.
- Drain without load: out_valid <= 0 next edge, state -> EMPTY. out_data and grant_idx hold their last values.
- FULL with out_ready=0:
  - All req_ready=0.
  - out_data, grant_idx and last_ptr hold.
  - Requests stay pending; lanes must keep req_valid/req_data stable.
- last_ptr updates only on an actual transfer, never on an idle cycle.
- P=1: lane 0 always wins; last_ptr is constant 0.
- Reset mid-transfer: the output word is discarded, out_valid=0 immediately (asynchronous), and priority returns to lane 0.
- A req_valid drop without a handshake is tolerated. Arbitration re-evaluates every cycle; only an accepted word updates state.

Optional Feature:
Macro ARB_LOCK_EN adds packet locking.
- With ARB_LOCK_EN defined:
  - Adds input req_last [P], one end-of-packet flag per lane.
  - Adds state LOCKED with a lock_idx register.
  - A transfer with req_last[winner]=0 enters LOCKED on lock_idx=winner.
  - While LOCKED, only lane lock_idx can be granted; other lanes' req_valid are ignored.
  - A transfer with req_last[lock_idx]=1 returns to UNLOCKED and sets last_ptr=lock_idx.
  - Reset clears to UNLOCKED.
- Without ARB_LOCK_EN:
  - req_last port is absent.
  - The grant rotates on every accepted word.

Test Plan:
- Reset release, all req_valid=0 -> out_valid=0, req_ready=0, busy=0, grant_idx=0 for the full idle period.
- P=4, req_valid=4'b1111 constant, out_ready=1, lane i data=0x10+i -> out_data sequence 0x10,0x11,0x12,0x13,0x10, one per cycle; grant_idx 0,1,2,3,0.
- req_valid=4'b1010, last_ptr=1 (after a lane-1 grant) -> lane 3 granted next, then lane 1; lanes 0/2 req_ready stay 0.
- FULL with out_ready=0 for 5 cycles, req_valid=4'b0100 -> req_ready=0 and out_data stable for all 5 cycles; the cycle out_ready=1 -> req_ready[2]=1, lane 2 data appears next cycle with no bubble.
- rst_n pulled low mid-stream while out_valid=1 -> out_valid=0 asynchronously; after release with req_valid=4'b1001, lane 0 is granted first.
- ARB_LOCK_EN, lane 2 sends 3 beats (req_last on the 3rd) while lanes 0,1 request -> out grant_idx 2,2,2 then 0; without the macro the grant order is 2,0,1,2.
